// File: rtl/gemm_pkg.sv
// Shared defaults, types and the saturating formatter for the GEMM sequencer output path.
package gemm_pkg;

    localparam int NL    = 8;
    localparam int ACC_W = 32;
    localparam int DW    = 16;

    typedef logic [NL*ACC_W-1:0] acc_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BEAT
    } out_st_e;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 << (DW-1)));

    // Clamp a signed accumulator into the signed beat range.
    function automatic logic [DW-1:0] sat_acc(input logic signed [ACC_W-1:0] a);
        if (a > SAT_HI) begin
            return {1'b0, {(DW-1){1'b1}}};
        end else if (a < SAT_LO) begin
            return {1'b1, {(DW-1){1'b0}}};
        end else begin
            return a[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/out_fifo.sv
// Result FIFO holding whole accumulator vectors; writes while full are ignored.
module out_fifo
    import gemm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  acc_vec_t                wr_data,
    input  logic                    rd_en,
    output acc_vec_t                rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  occ_nxt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    acc_vec_t        mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   occ;
    logic            wr_ok;

    assign wr_ok   = wr_en & ~full;
    assign full    = (occ == CW'(DEPTH));
    assign empty   = (occ == '0);
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    // Reads are only issued by the drain FSM while the FIFO is known non-empty.
    always_comb begin
        occ_nxt = occ;
        case ({wr_ok, rd_en})
            2'b10:   occ_nxt = occ + CW'(1);
            2'b01:   occ_nxt = occ - CW'(1);
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (rd_en) begin
                rptr <= rptr + PW'(1);
            end
            occ <= occ_nxt;
        end
    end

endmodule

// File: rtl/out_ctl.sv
// Output controller: buffers kernel results and streams them one lane per beat.
// Build option: define OUT_SAT_EN to saturate each beat instead of truncating it.
module out_ctl
    import gemm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int KPJ   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_init,
    input  logic            k_fin,
    input  acc_vec_t        acc_in,
    output logic            out_busy,
    output logic            outr,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic            m_last,
    output logic            ovf
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = $clog2(NL);
    localparam int KW = (KPJ > 1) ? $clog2(KPJ) : 1;

    localparam logic [CW-1:0] BUSY_TH   = CW'(DEPTH - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(NL - 1);
    localparam logic [KW-1:0] KC_LAST   = KW'(KPJ - 1);

    out_st_e        state;
    out_st_e        state_nxt;
    acc_vec_t       rd_data;
    acc_vec_t       shift_reg;
    logic [LW-1:0]  lane;
    logic [KW-1:0]  kc;
    logic [CW-1:0]  occ_nxt;
    logic           fifo_full;
    logic           fifo_empty;
    logic           rd_en;
    logic           hs;
    logic           hs_last;
    logic [DW-1:0]  beat;

    out_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (k_fin),
        .wr_data (acc_in),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .occ_nxt (occ_nxt)
    );

    assign hs      = m_valid & m_ready;
    assign hs_last = hs & (lane == LANE_LAST);

`ifdef OUT_SAT_EN
    assign beat = sat_acc(shift_reg[ACC_W-1:0]);
`else
    assign beat = shift_reg[DW-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = BEAT;
            end
            BEAT: begin
                if (hs_last) begin
                    state_nxt = fifo_empty ? IDLE : LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_valid = (state == BEAT);
        rd_en   = (state == LOAD);
        m_data  = m_valid ? beat : '0;
        m_last  = m_valid & (lane == LANE_LAST) & (kc == KC_LAST);
    end

    // Lane 0 always sits in the low word; each accepted beat shifts the next lane down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            lane      <= '0;
        end else if (rd_en) begin
            shift_reg <= rd_data;
            lane      <= '0;
        end else if (hs) begin
            shift_reg <= shift_reg >> ACC_W;
            lane      <= lane + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kc <= '0;
        end else if (s_init) begin
            kc <= '0;
        end else if (hs_last) begin
            kc <= (kc == KC_LAST) ? '0 : kc + KW'(1);
        end
    end

    // Flags follow next-state values so they line up with the cycle the change takes effect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_busy <= 1'b0;
            outr     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            out_busy <= (occ_nxt >= BUSY_TH);
            outr     <= (occ_nxt != '0) | (state_nxt != IDLE);
            if (k_fin & fifo_full) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_ctl.sv
// Directed self-checking bench for out_ctl; expected beats are queued as kernels are issued.
module tb_out_ctl;
    import gemm_pkg::*;

    localparam int DEPTH = 4;
    localparam int KPJ   = 4;

    logic           clk     = 1'b0;
    logic           rst     = 1'b0;
    logic           s_init  = 1'b0;
    logic           k_fin   = 1'b0;
    acc_vec_t       acc_in  = '0;
    logic           m_ready = 1'b0;
    logic           out_busy;
    logic           outr;
    logic           m_valid;
    logic [DW-1:0]  m_data;
    logic           m_last;
    logic           ovf;

    int             assert_cnt = 0;
    int             fail_cnt   = 0;
    int             beat_cnt   = 0;
    int             last_cnt   = 0;
    int             model_kc   = 0;
    bit             rand_ready = 1'b0;
    logic [DW-1:0]  exp_data_q [$];
    logic           exp_last_q [$];
    logic [DW-1:0]  exp_d;
    logic           exp_l;
    logic           prev_stall = 1'b0;
    logic [DW-1:0]  prev_data  = '0;
    logic           prev_last  = 1'b0;

    always #5 clk = ~clk;

    out_ctl #(
        .DEPTH    (DEPTH),
        .KPJ      (KPJ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_init   (s_init),
        .k_fin    (k_fin),
        .acc_in   (acc_in),
        .out_busy (out_busy),
        .outr     (outr),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .ovf      (ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic acc_vec_t seq_vec(input int base, input int step);
        acc_vec_t v;
        for (int l = 0; l < NL; l++) v[l*ACC_W +: ACC_W] = ACC_W'(base + l*step);
        return v;
    endfunction

    // Only valid for vectors whose lanes already fit in DW signed bits.
    function automatic logic [NL*DW-1:0] low16(input acc_vec_t v);
        logic [NL*DW-1:0] r;
        for (int l = 0; l < NL; l++) r[l*DW +: DW] = v[l*ACC_W +: DW];
        return r;
    endfunction

    task automatic applyStimulus(input acc_vec_t vec, input logic [NL*DW-1:0] exp_vec, input bit accepted);
        k_fin  = 1'b1;
        acc_in = vec;
        tick();
        k_fin  = 1'b0;
        if (accepted) begin
            for (int l = 0; l < NL; l++) begin
                exp_data_q.push_back(exp_vec[l*DW +: DW]);
                exp_last_q.push_back((l == NL-1) && (model_kc == KPJ-1));
            end
            model_kc = (model_kc == KPJ-1) ? 0 : model_kc + 1;
        end
    endtask

    task automatic pulse_s_init();
        s_init = 1'b1;
        tick();
        s_init = 1'b0;
        model_kc = 0;
    endtask

    task automatic wait_drain(input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_data_q.size() == 0 && !outr && !m_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("drain_done", 32'(done), 1);
    endtask

    // Stream monitor: ordered beat check plus hold-stability while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_valid", 32'(m_valid), 1);
                checkOutput("hold_data", 32'(m_data), 32'(prev_data));
                checkOutput("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                checkOutput("beat_expected", 32'(exp_data_q.size() != 0), 1);
                if (exp_data_q.size() != 0) begin
                    exp_d = exp_data_q.pop_front();
                    exp_l = exp_last_q.pop_front();
                    checkOutput("beat_data", 32'(m_data), 32'(exp_d));
                    checkOutput("beat_last", 32'(m_last), 32'(exp_l));
                end
                beat_cnt++;
                if (m_last) last_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        acc_vec_t          v;
        acc_vec_t          sat_vec;
        logic [NL*DW-1:0]  sat_exp;
        int                b0;
        int                l0;
        int                r;

        // Reset state
        repeat (2) tick();
        checkOutput("rst_valid", 32'(m_valid), 0);
        checkOutput("rst_data", 32'(m_data), 0);
        checkOutput("rst_last", 32'(m_last), 0);
        checkOutput("rst_busy", 32'(out_busy), 0);
        checkOutput("rst_outr", 32'(outr), 0);
        checkOutput("rst_ovf", 32'(ovf), 0);
        rst = 1'b1;
        tick();

        // Single kernel: lanes 1..8, first beat three cycles after k_fin
        pulse_s_init();
        m_ready = 1'b1;
        v = seq_vec(1, 1);
        applyStimulus(v, low16(v), 1'b1);
        checkOutput("lat_t1_valid", 32'(m_valid), 0);
        checkOutput("lat_t1_outr", 32'(outr), 1);
        tick();
        checkOutput("lat_t2_valid", 32'(m_valid), 0);
        tick();
        checkOutput("lat_t3_valid", 32'(m_valid), 1);
        checkOutput("lat_t3_data", 32'(m_data), 1);
        checkOutput("lat_t3_last", 32'(m_last), 0);
        repeat (7) tick();
        checkOutput("beat8_data", 32'(m_data), 8);
        checkOutput("beat8_outr", 32'(outr), 1);
        tick();
        checkOutput("post_outr", 32'(outr), 0);
        checkOutput("post_valid", 32'(m_valid), 0);

        // Full job: four kernels ten cycles apart, m_last only on beat 32
        pulse_s_init();
        b0 = beat_cnt;
        l0 = last_cnt;
        for (int k = 0; k < KPJ; k++) begin
            v = seq_vec(10*k - 15, 3);
            applyStimulus(v, low16(v), 1'b1);
            checkOutput("job_busy", 32'(out_busy), 0);
            repeat (9) tick();
        end
        wait_drain(100);
        checkOutput("job_beats", 32'(beat_cnt - b0), 32);
        checkOutput("job_lasts", 32'(last_cnt - l0), 1);

        // Backpressure: first kernel moves into the shifter, so the FIFO fills on the fifth
        pulse_s_init();
        m_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            v = seq_vec(200*k - 300, 5);
            applyStimulus(v, low16(v), k < 5);
            checkOutput("bp_busy", 32'(out_busy), 32'(k >= 3));
            checkOutput("bp_ovf", 32'(ovf), 32'(k >= 5));
            repeat (9) tick();
        end
        checkOutput("bp_stalled_valid", 32'(m_valid), 1);
        checkOutput("bp_stalled_data", 32'(m_data), 16'hFED4);
        m_ready = 1'b1;
        wait_drain(200);
        checkOutput("bp_busy_clear", 32'(out_busy), 0);
        checkOutput("ovf_sticky", 32'(ovf), 1);

        // Reset mid-drain
        m_ready = 1'b0;
        v = seq_vec(50, 1);
        applyStimulus(v, low16(v), 1'b1);
        repeat (2) tick();
        checkOutput("mid_pre_valid", 32'(m_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        exp_data_q.delete();
        exp_last_q.delete();
        model_kc = 0;
        checkOutput("mid_valid", 32'(m_valid), 0);
        checkOutput("mid_data", 32'(m_data), 0);
        checkOutput("mid_last", 32'(m_last), 0);
        checkOutput("mid_outr", 32'(outr), 0);
        checkOutput("mid_busy", 32'(out_busy), 0);
        checkOutput("mid_ovf", 32'(ovf), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checkOutput("rel_outr", 32'(outr), 0);
        m_ready = 1'b1;
        v = seq_vec(-3, 2);
        applyStimulus(v, low16(v), 1'b1);
        repeat (2) tick();
        checkOutput("rel_lane0", 32'(m_data), 16'hFFFD);
        wait_drain(50);

        // Formatter: saturating vs truncating build
        sat_vec = {32'h8000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0001_2345,
                   32'hFFFF_8000, 32'h0000_7FFF, 32'hFFFE_0000, 32'h0001_0000};
`ifdef OUT_SAT_EN
        sat_exp = {16'h8000, 16'h0005, 16'hFFFF, 16'h7FFF,
                   16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
`else
        sat_exp = {16'h0000, 16'h0005, 16'hFFFF, 16'h2345,
                   16'h8000, 16'h7FFF, 16'h0000, 16'h0000};
`endif
        applyStimulus(sat_vec, sat_exp, 1'b1);
        repeat (2) tick();
        checkOutput("fmt_lane0", 32'(m_data), 32'(sat_exp[DW-1:0]));
        tick();
        checkOutput("fmt_lane1", 32'(m_data), 32'(sat_exp[2*DW-1:DW]));
        wait_drain(50);

        // Random sink readiness over three jobs; kernels respect out_busy
        l0 = last_cnt;
        rand_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            pulse_s_init();
            for (int k = 0; k < KPJ; k++) begin
                for (int w = 0; w < 200 && out_busy; w++) tick();
                checkOutput("rnd_busy_wait", 32'(out_busy), 0);
                for (int l = 0; l < NL; l++) begin
                    r = int'($urandom_range(0, 65535)) - 32768;
                    v[l*ACC_W +: ACC_W] = ACC_W'(r);
                end
                applyStimulus(v, low16(v), 1'b1);
                repeat (2) tick();
            end
            wait_drain(400);
        end
        rand_ready = 1'b0;
        m_ready = 1'b1;
        checkOutput("rnd_last_count", 32'(last_cnt - l0), 3);
        checkOutput("rnd_ovf", 32'(ovf), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
